// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: switch-bank bus between raw pins, the debouncer and its consumers.
// SW_EDGE_FLAGS_EN adds the sw_rise/sw_fall strobes.
interface switch_debouncer_if #(
  parameter int NUM_SW = 10
);
  logic [NUM_SW-1:0] sw_in;
  logic [NUM_SW-1:0] sw_stable;
  logic [NUM_SW-1:0] sw_changed;
  logic              any_changed;
`ifdef SW_EDGE_FLAGS_EN
  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;
  modport slave (input sw_in, output sw_stable, sw_changed, any_changed, sw_rise, sw_fall);
  modport master (output sw_in, input sw_stable, sw_changed, any_changed, sw_rise, sw_fall);
`else
  modport slave (input sw_in, output sw_stable, sw_changed, any_changed);
  modport master (output sw_in, input sw_stable, sw_changed, any_changed);
`endif
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes and debounces a switch bank, emitting registered change strobes.
// SW_EDGE_FLAGS_EN adds registered per-bit rise/fall strobes.
module switch_debouncer #(
  parameter int NUM_SW          = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_debouncer_if.slave sw
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]     cnt_q  [NUM_SW];
  logic [CW-1:0]     cnt_d  [NUM_SW];
  logic [NUM_SW-1:0] sync;
  logic [NUM_SW-1:0] upd;
  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [NUM_SW-1:0] changed_q;
  logic              any_q;
  assign sync = sync_q[SYNC_STAGES-1];
  // Any sample that agrees with the stable value restarts that bit's count.
  always_comb begin
    upd = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        upd[i]   = (cnt_q[i] == CNT_LAST);
        cnt_d[i] = upd[i] ? '0 : cnt_q[i] + CW'(1);
      end
    end
    stable_d = stable_q ^ upd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
      stable_q  <= '0;
      changed_q <= '0;
      any_q     <= 1'b0;
    end else begin
      sync_q[0] <= sw.sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= upd;
      any_q     <= |upd;
    end
  end
  assign sw.sw_stable   = stable_q;
  assign sw.sw_changed  = changed_q;
  assign sw.any_changed = any_q;
`ifdef SW_EDGE_FLAGS_EN
  logic [NUM_SW-1:0] rise_q, fall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & sync;
      fall_q <= upd & ~sync;
    end
  end
  assign sw.sw_rise = rise_q;
  assign sw.sw_fall = fall_q;
`else
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: scoreboard bench; stimulus queues expected strobes, a monitor pops and compares them.
module tb_switch_debouncer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  typedef struct {
    int         cyc;
    logic [9:0] st;
    logic [9:0] ch;
    logic [9:0] ri;
    logic [9:0] fa;
  } exp_t;
  exp_t q[$];
  switch_debouncer_if #(.NUM_SW(10)) sw_if ();
  switch_debouncer #(.NUM_SW(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask
  task automatic push(input logic [9:0] st, input logic [9:0] ch, input logic [9:0] ri, input logic [9:0] fa);
    exp_t e;
    e.cyc = cyc + 6;
    e.st  = st;
    e.ch  = ch;
    e.ri  = ri;
    e.fa  = fa;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (sw_if.any_changed || (|sw_if.sw_changed)) begin
      exp_t e;
      chk("any_changed", 32'(sw_if.any_changed), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_change", 32'(sw_if.sw_changed), 32'd0);
      end else begin
        e = q.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("sw_stable", 32'(sw_if.sw_stable), 32'(e.st));
        chk("sw_changed", 32'(sw_if.sw_changed), 32'(e.ch));
`ifdef SW_EDGE_FLAGS_EN
        chk("sw_rise", 32'(sw_if.sw_rise), 32'(e.ri));
        chk("sw_fall", 32'(sw_if.sw_fall), 32'(e.fa));
`endif
      end
    end
  end
  initial begin
    sw_if.sw_in = 10'h3FF;
    repeat (3) @(negedge clk);
    chk("reset_stable", 32'(sw_if.sw_stable), 32'd0);
    chk("reset_changed", 32'(sw_if.sw_changed), 32'd0);
    chk("reset_any", 32'(sw_if.any_changed), 32'd0);
    @(negedge clk);
    push(10'h3FF, 10'h3FF, 10'h3FF, 10'h000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    push(10'h000, 10'h3FF, 10'h000, 10'h3FF);
    sw_if.sw_in = 10'h000;
    repeat (10) @(negedge clk);
    push(10'h008, 10'h008, 10'h008, 10'h000);
    sw_if.sw_in = 10'h008;
    repeat (10) @(negedge clk);
    sw_if.sw_in = 10'h00C;
    repeat (3) @(negedge clk);
    sw_if.sw_in = 10'h008;
    repeat (10) @(negedge clk);
    sw_if.sw_in = 10'h009;
    repeat (3) @(negedge clk);
    sw_if.sw_in = 10'h008;
    @(negedge clk);
    push(10'h009, 10'h001, 10'h001, 10'h000);
    sw_if.sw_in = 10'h009;
    repeat (12) @(negedge clk);
    push(10'h20B, 10'h202, 10'h202, 10'h000);
    sw_if.sw_in = 10'h20B;
    repeat (10) @(negedge clk);
    push(10'h22B, 10'h020, 10'h020, 10'h000);
    sw_if.sw_in = 10'h22B;
    repeat (10) @(negedge clk);
    push(10'h20B, 10'h020, 10'h000, 10'h020);
    sw_if.sw_in = 10'h20B;
    repeat (10) @(negedge clk);
    sw_if.sw_in = 10'h28B;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_stable", 32'(sw_if.sw_stable), 32'd0);
    chk("async_changed", 32'(sw_if.sw_changed), 32'd0);
    chk("async_any", 32'(sw_if.any_changed), 32'd0);
    @(negedge clk);
    push(10'h28B, 10'h28B, 10'h28B, 10'h000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
